// File: rtl/data_bus_arbiter.sv
// -----------------------------------------------------------------------------
// data_bus_arbiter
//
// Purpose:
//   Shares the single data port of miriscv_ram between two masters.
//   Master 0 is the core data interface. Master 1 is a secondary requester,
//   such as a program loader or DMA engine.
//   A request is granted in the cycle it is presented. The synchronous RAM
//   returns its response one cycle after the grant. Grants may be issued
//   back-to-back on every cycle.
//
// Parameters:
//   FIXED_PRIO : 0 = conflicts are resolved round-robin.
//                1 = master 0 wins conflicts, subject to the anti-starvation
//                    counter.
//   MAX_WAIT   : in fixed-priority mode, the number of consecutive cycles
//                master 1 may be denied before it is force-granted (1..255).
//
// Ports:
//   clk_i, rst_n_i             clock, asynchronous active-low reset
//   mX_req_i / mX_we_i         master X request and write enable
//   mX_be_i / mX_addr_i        master X byte enables and address
//   mX_wdata_i                 master X write data
//   mX_gnt_o                   master X granted this cycle
//   mX_rvalid_o / mX_rdata_o   master X response valid and read data
//                              (one cycle after the grant)
//   s_req_o .. s_wdata_o       request towards the slave RAM (zero when idle)
//   s_rdata_i                  slave read data, valid one cycle after s_req_o
//
// Handshake:
//   A master raises req with a stable payload and holds both until it sees
//   gnt in the same cycle. req && gnt is a completed transfer. Every completed
//   transfer, read or write, produces exactly one rvalid pulse on the next
//   cycle. A master may withdraw req before it is granted. Nothing is issued
//   to the slave in that case.
// -----------------------------------------------------------------------------
module data_bus_arbiter #(
    parameter int FIXED_PRIO = 0,
    parameter int MAX_WAIT   = 8
) (
    input  logic        clk_i,
    input  logic        rst_n_i,

    input  logic        m0_req_i,
    input  logic        m0_we_i,
    input  logic [3:0]  m0_be_i,
    input  logic [31:0] m0_addr_i,
    input  logic [31:0] m0_wdata_i,
    output logic        m0_gnt_o,
    output logic        m0_rvalid_o,
    output logic [31:0] m0_rdata_o,

    input  logic        m1_req_i,
    input  logic        m1_we_i,
    input  logic [3:0]  m1_be_i,
    input  logic [31:0] m1_addr_i,
    input  logic [31:0] m1_wdata_i,
    output logic        m1_gnt_o,
    output logic        m1_rvalid_o,
    output logic [31:0] m1_rdata_o,

    output logic        s_req_o,
    output logic        s_we_o,
    output logic [3:0]  s_be_o,
    output logic [31:0] s_addr_o,
    output logic [31:0] s_wdata_o,
    input  logic [31:0] s_rdata_i
);

    // The counter is 8 bits wide, so MAX_WAIT is limited to 1..255.
    localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

    // -------------------------------------------------------------------------
    // Registered arbitration / response state
    // -------------------------------------------------------------------------
    logic       resp_pend;    // a granted access is being answered this cycle
    logic       resp_owner;   // which master that answer belongs to
    logic       last_owner;   // master granted most recently
    logic [7:0] wait_cnt;     // consecutive cycles master 1 has been denied

    logic       resp_pend_nxt;
    logic       resp_owner_nxt;
    logic       last_owner_nxt;
    logic [7:0] wait_cnt_nxt;

    // -------------------------------------------------------------------------
    // Grant selection
    // -------------------------------------------------------------------------
    logic conflict;
    logic starved;
    logic pick_m1;
    logic gnt0;
    logic gnt1;

    always_comb begin
        conflict = m0_req_i & m1_req_i;
        starved  = (wait_cnt == MAX_WAIT_C);
        pick_m1  = 1'b0;

        if (conflict) begin
            if (FIXED_PRIO != 0) begin
                // Master 0 wins unless master 1 has waited its full budget.
                pick_m1 = starved;
            end else begin
                // Alternate: the master that did not win last time gets it.
                pick_m1 = ~last_owner;
            end
        end else begin
            pick_m1 = m1_req_i;
        end

        gnt1 = pick_m1;
        gnt0 = m0_req_i & ~pick_m1;
    end

    assign m0_gnt_o = gnt0;
    assign m1_gnt_o = gnt1;

    // -------------------------------------------------------------------------
    // Slave request mux. Idle outputs are forced to zero, not left floating.
    // -------------------------------------------------------------------------
    always_comb begin
        s_req_o   = gnt0 | gnt1;
        s_we_o    = 1'b0;
        s_be_o    = 4'b0000;
        s_addr_o  = 32'h0000_0000;
        s_wdata_o = 32'h0000_0000;

        if (gnt0) begin
            s_we_o    = m0_we_i;
            s_be_o    = m0_be_i;
            s_addr_o  = m0_addr_i;
            s_wdata_o = m0_wdata_i;
        end else if (gnt1) begin
            s_we_o    = m1_we_i;
            s_be_o    = m1_be_i;
            s_addr_o  = m1_addr_i;
            s_wdata_o = m1_wdata_i;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        resp_pend_nxt  = 1'b0;
        resp_owner_nxt = resp_owner;
        last_owner_nxt = last_owner;
        wait_cnt_nxt   = wait_cnt;

        if (gnt0 | gnt1) begin
            resp_pend_nxt  = 1'b1;
            resp_owner_nxt = gnt1;
            last_owner_nxt = gnt1;
        end

        // The counter measures an unbroken run of denials. Any gap in
        // master 1's request, or a grant to master 1, starts the run again.
        if (!m1_req_i || gnt1) begin
            wait_cnt_nxt = 8'd0;
        end else if (wait_cnt < MAX_WAIT_C) begin
            wait_cnt_nxt = wait_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            resp_pend  <= 1'b0;
            resp_owner <= 1'b0;
            last_owner <= 1'b1;   // so master 0 wins the first conflict
            wait_cnt   <= 8'd0;
        end else begin
            resp_pend  <= resp_pend_nxt;
            resp_owner <= resp_owner_nxt;
            last_owner <= last_owner_nxt;
            wait_cnt   <= wait_cnt_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // Response routing. Read data reaches only the owning master. The other
    // master sees zero, so the data is never left floating.
    // -------------------------------------------------------------------------
    always_comb begin
        m0_rvalid_o = resp_pend & ~resp_owner;
        m1_rvalid_o = resp_pend &  resp_owner;
        m0_rdata_o  = m0_rvalid_o ? s_rdata_i : 32'h0000_0000;
        m1_rdata_o  = m1_rvalid_o ? s_rdata_i : 32'h0000_0000;
    end

endmodule

// File: tb/tb_data_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_data_bus_arbiter
//
// Two arbiters share one set of master stimulus:
//   index 0 ("rr") : FIXED_PRIO=0, MAX_WAIT=8
//   index 1 ("fp") : FIXED_PRIO=1, MAX_WAIT=3
// Each arbiter has its own word-addressed RAM acting as the slave.
// A rule-level model predicts every output on every cycle. Directed sequences
// pin the model with literal values.
// -----------------------------------------------------------------------------
module tb_data_bus_arbiter;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // ---------------- shared master stimulus ----------------
    logic        m0_req = 1'b0, m0_we = 1'b0;
    logic [3:0]  m0_be = '0;
    logic [31:0] m0_addr = '0, m0_wdata = '0;
    logic        m1_req = 1'b0, m1_we = 1'b0;
    logic [3:0]  m1_be = '0;
    logic [31:0] m1_addr = '0, m1_wdata = '0;

    // ---------------- per-arbiter outputs ----------------
    logic [1:0]       o_gnt0, o_gnt1, o_rv0, o_rv1, o_sreq, o_swe;
    logic [1:0][31:0] o_rd0, o_rd1, o_saddr, o_swd;
    logic [1:0][3:0]  o_sbe;
    logic [1:0][31:0] s_rdata = '0;

    data_bus_arbiter #(.FIXED_PRIO(0), .MAX_WAIT(8)) dut_rr (
        .clk_i(clk), .rst_n_i(rst_n),
        .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_be_i(m0_be), .m0_addr_i(m0_addr),
        .m0_wdata_i(m0_wdata), .m0_gnt_o(o_gnt0[0]), .m0_rvalid_o(o_rv0[0]),
        .m0_rdata_o(o_rd0[0]),
        .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_be_i(m1_be), .m1_addr_i(m1_addr),
        .m1_wdata_i(m1_wdata), .m1_gnt_o(o_gnt1[0]), .m1_rvalid_o(o_rv1[0]),
        .m1_rdata_o(o_rd1[0]),
        .s_req_o(o_sreq[0]), .s_we_o(o_swe[0]), .s_be_o(o_sbe[0]), .s_addr_o(o_saddr[0]),
        .s_wdata_o(o_swd[0]), .s_rdata_i(s_rdata[0])
    );

    data_bus_arbiter #(.FIXED_PRIO(1), .MAX_WAIT(3)) dut_fp (
        .clk_i(clk), .rst_n_i(rst_n),
        .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_be_i(m0_be), .m0_addr_i(m0_addr),
        .m0_wdata_i(m0_wdata), .m0_gnt_o(o_gnt0[1]), .m0_rvalid_o(o_rv0[1]),
        .m0_rdata_o(o_rd0[1]),
        .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_be_i(m1_be), .m1_addr_i(m1_addr),
        .m1_wdata_i(m1_wdata), .m1_gnt_o(o_gnt1[1]), .m1_rvalid_o(o_rv1[1]),
        .m1_rdata_o(o_rd1[1]),
        .s_req_o(o_sreq[1]), .s_we_o(o_swe[1]), .s_be_o(o_sbe[1]), .s_addr_o(o_saddr[1]),
        .s_wdata_o(o_swd[1]), .s_rdata_i(s_rdata[1])
    );

    // ---------------- memory contents ----------------
    function automatic logic [31:0] init_word(input int idx);
        if (idx == 4) return 32'hDEAD_BEEF;       // address 0x10
        if (idx == 8) return 32'h0000_0000;       // address 0x20
        return 32'h1357_0000 ^ (32'(idx) * 32'h0001_0203);
    endfunction

    // Slave RAMs: synchronous read (old contents on a write), byte-enabled write.
    logic [31:0] ram [2][64];
    bit          ram_wr [2][64];

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (o_sreq[k]) begin : ram_access
                int          idx;
                logic [31:0] w;
                idx = int'(o_saddr[k][7:2]);
                w   = ram_wr[k][idx] ? ram[k][idx] : init_word(idx);
                s_rdata[k] <= w;
                if (o_swe[k]) begin
                    for (int b = 0; b < 4; b++)
                        if (o_sbe[k][b]) w[8*b +: 8] = o_swd[k][8*b +: 8];
                    ram[k][idx]    <= w;
                    ram_wr[k][idx] <= 1'b1;
                end
            end
        end
    end

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit          mdl_last [2];
    int          mdl_wait [2];
    logic [31:0] mdl_mem  [2][64];
    bit          mdl_wr   [2][64];
    logic [32:0] exp_q_rr [$];      // {owner, rdata} of the response due next cycle
    logic [32:0] exp_q_fp [$];

    task automatic model_check(input int k);
        int          win;
        int          maxw;
        int          idx;
        bit          has_resp;
        logic [32:0] resp;
        logic [31:0] old_w, new_w, e_addr, e_wd;
        logic        e_we;
        logic [3:0]  e_be;
        string       p;

        p        = (k == 0) ? "rr" : "fp";
        maxw     = (k == 0) ? 8 : 3;
        has_resp = 1'b0;
        resp     = '0;

        if (!rst_n) begin
            mdl_last[k] = 1'b1;
            mdl_wait[k] = 0;
            if (k == 0) exp_q_rr.delete(); else exp_q_fp.delete();
        end

        // Who wins this cycle, by the arbitration rules
        if (!rst_n)                     win = -1;
        else if (m0_req && m1_req) begin
            if (k == 0) win = mdl_last[k] ? 0 : 1;
            else        win = (mdl_wait[k] == maxw) ? 1 : 0;
        end
        else if (m0_req)                win = 0;
        else if (m1_req)                win = 1;
        else                            win = -1;

        e_we = 1'b0; e_be = '0; e_addr = '0; e_wd = '0;
        if (win == 0) begin e_we = m0_we; e_be = m0_be; e_addr = m0_addr; e_wd = m0_wdata; end
        if (win == 1) begin e_we = m1_we; e_be = m1_be; e_addr = m1_addr; e_wd = m1_wdata; end

        if (k == 0) begin
            if (exp_q_rr.size() > 0) begin has_resp = 1'b1; resp = exp_q_rr.pop_front(); end
        end else begin
            if (exp_q_fp.size() > 0) begin has_resp = 1'b1; resp = exp_q_fp.pop_front(); end
        end

        check({p, " m0_gnt"},    32'(o_gnt0[k]),  32'(win == 0));
        check({p, " m1_gnt"},    32'(o_gnt1[k]),  32'(win == 1));
        check({p, " s_req"},     32'(o_sreq[k]),  32'(win >= 0));
        check({p, " s_we"},      32'(o_swe[k]),   32'(e_we));
        check({p, " s_be"},      32'(o_sbe[k]),   32'(e_be));
        check({p, " s_addr"},    o_saddr[k],      e_addr);
        check({p, " s_wdata"},   o_swd[k],        e_wd);
        check({p, " m0_rvalid"}, 32'(o_rv0[k]),   32'(has_resp && !resp[32]));
        check({p, " m1_rvalid"}, 32'(o_rv1[k]),   32'(has_resp &&  resp[32]));
        check({p, " m0_rdata"},  o_rd0[k],        (has_resp && !resp[32]) ? resp[31:0] : 32'h0);
        check({p, " m1_rdata"},  o_rd1[k],        (has_resp &&  resp[32]) ? resp[31:0] : 32'h0);

        // Advance the model to the next cycle
        if (rst_n) begin
            if (win >= 0) begin
                mdl_last[k] = (win == 1);
                idx   = int'(e_addr[7:2]);
                old_w = mdl_wr[k][idx] ? mdl_mem[k][idx] : init_word(idx);
                if (k == 0) exp_q_rr.push_back({win == 1, old_w});
                else        exp_q_fp.push_back({win == 1, old_w});
                if (e_we) begin
                    new_w = old_w;
                    for (int b = 0; b < 4; b++)
                        if (e_be[b]) new_w[8*b +: 8] = e_wd[8*b +: 8];
                    mdl_mem[k][idx] = new_w;
                    mdl_wr[k][idx]  = 1'b1;
                end
            end
            if (m1_req && win != 1) mdl_wait[k] = (mdl_wait[k] < maxw) ? mdl_wait[k] + 1 : maxw;
            else                    mdl_wait[k] = 0;
        end
    endtask

    always @(negedge clk) begin
        model_check(0);
        model_check(1);
    end

    // ---------------- driver tasks ----------------
    task automatic drive_idle();
        m0_req = 0; m0_we = 0; m0_be = '0; m0_addr = '0; m0_wdata = '0;
        m1_req = 0; m1_we = 0; m1_be = '0; m1_addr = '0; m1_wdata = '0;
    endtask

    task automatic drive_m0(input logic req, input logic we, input logic [3:0] be,
                            input logic [31:0] addr, input logic [31:0] wd);
        m0_req = req; m0_we = we; m0_be = be; m0_addr = addr; m0_wdata = wd;
    endtask

    task automatic drive_m1(input logic req, input logic we, input logic [3:0] be,
                            input logic [31:0] addr, input logic [31:0] wd);
        m1_req = req; m1_we = we; m1_be = be; m1_addr = addr; m1_wdata = wd;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        step();
        drive_idle();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    // ---------------- directed sequences + random run ----------------
    logic [7:0] rr_g1;
    logic [7:0] fp_g1;

    initial begin
        drive_idle();

        // Reset state
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check("reset m0_gnt",    32'(o_gnt0[k]), 32'h0);
            check("reset m1_rvalid", 32'(o_rv1[k]),  32'h0);
            check("reset s_req",     32'(o_sreq[k]), 32'h0);
            check("reset m0_rdata",  o_rd0[k],       32'h0);
        end
        step();
        rst_n = 1'b1;

        // Single master read of 0x10
        step();
        drive_m0(1, 0, 4'hF, 32'h10, 32'h0);
        @(negedge clk);
        check("single m0_gnt c0", 32'(o_gnt0[0]), 32'h1);
        check("single s_addr c0", o_saddr[0],     32'h10);
        step();
        drive_idle();
        @(negedge clk);
        check("single m0_rvalid c1", 32'(o_rv0[0]), 32'h1);
        check("single m0_rdata c1",  o_rd0[0],      32'hDEAD_BEEF);
        check("single m1_rvalid c1", 32'(o_rv1[0]), 32'h0);
        check("single m1_rdata c1",  o_rd1[0],      32'h0);

        // m1 write then read of 0x20, pipelined
        do_reset();
        step();
        drive_m1(1, 1, 4'b0011, 32'h20, 32'hA5A5_A5A5);
        @(negedge clk);
        check("wr m1_gnt c0", 32'(o_gnt1[1]), 32'h1);
        step();
        drive_m1(1, 0, 4'hF, 32'h20, 32'h0);
        @(negedge clk);
        check("rd m1_gnt c1",    32'(o_gnt1[1]), 32'h1);
        check("wr m1_rvalid c1", 32'(o_rv1[1]),  32'h1);
        step();
        drive_idle();
        @(negedge clk);
        check("rd m1_rvalid c2", 32'(o_rv1[1]), 32'h1);
        check("rd m1_rdata c2",  o_rd1[1],      32'h0000_A5A5);

        // Continuous conflict from reset: round-robin and fixed priority
        do_reset();
        rr_g1 = 8'b1010_1010;
        fp_g1 = 8'b1000_1000;
        for (int i = 0; i < 8; i++) begin
            step();
            drive_m0(1, 0, 4'hF, 32'h10, 32'h0);
            drive_m1(1, 0, 4'hF, 32'h24, 32'h0);
            @(negedge clk);
            check($sformatf("rr m1_gnt c%0d", i), 32'(o_gnt1[0]), 32'(rr_g1[i]));
            check($sformatf("fp m1_gnt c%0d", i), 32'(o_gnt1[1]), 32'(fp_g1[i]));
            if (i > 0) begin
                check($sformatf("rr m1_rvalid c%0d", i), 32'(o_rv1[0]), 32'(rr_g1[i-1]));
                check($sformatf("fp m1_rvalid c%0d", i), 32'(o_rv1[1]), 32'(fp_g1[i-1]));
            end
        end

        // Reset asserted between edges after a grant
        do_reset();
        step();
        drive_m0(1, 0, 4'hF, 32'h10, 32'h0);
        #2;
        drive_idle();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst rr m0_rvalid", 32'(o_rv0[0]), 32'h0);
        check("midrst fp m0_rvalid", 32'(o_rv0[1]), 32'h0);
        step();
        drive_m0(1, 0, 4'hF, 32'h14, 32'h0);
        drive_m1(1, 0, 4'hF, 32'h18, 32'h0);
        @(negedge clk);
        check("midrst rr first conflict m0", 32'(o_gnt0[0]), 32'h1);
        check("midrst fp first conflict m0", 32'(o_gnt0[1]), 32'h1);

        // Withdrawn request: the starvation run must restart from zero
        do_reset();
        step();
        drive_m0(1, 0, 4'hF, 32'h14, 32'h0);
        drive_m1(1, 0, 4'hF, 32'h18, 32'h0);
        @(negedge clk);
        check("withdraw fp m1_gnt c0", 32'(o_gnt1[1]), 32'h0);
        step();
        drive_idle();
        @(negedge clk);
        check("withdraw fp m1_gnt c1",    32'(o_gnt1[1]), 32'h0);
        check("withdraw fp m1_rvalid c1", 32'(o_rv1[1]),  32'h0);
        for (int i = 0; i < 4; i++) begin
            step();
            drive_m0(1, 0, 4'hF, 32'h14, 32'h0);
            drive_m1(1, 0, 4'hF, 32'h18, 32'h0);
            @(negedge clk);
            check($sformatf("withdraw fp m1_gnt run c%0d", i), 32'(o_gnt1[1]), 32'(i == 3));
        end

        // Randomised traffic with occasional mid-cycle resets
        for (int c = 0; c < 3000; c++) begin
            step();
            if (!rst_n) rst_n = 1'b1;
            if ($urandom_range(0, 299) == 0) begin
                drive_idle();
                rst_n = 1'b0;
            end else begin
                drive_m0($urandom_range(0, 9) < 6, $urandom_range(0, 1) == 1,
                         4'($urandom_range(0, 15)), 32'($urandom_range(0, 63)) << 2, $urandom);
                drive_m1($urandom_range(0, 9) < 6, $urandom_range(0, 1) == 1,
                         4'($urandom_range(0, 15)), 32'($urandom_range(0, 63)) << 2, $urandom);
            end
        end
        step();
        rst_n = 1'b1;
        drive_idle();
        repeat (3) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/data_bus_arbiter.md
Name: data_bus_arbiter

Overview:
- Two-master, one-slave arbiter for the single data port of miriscv_ram.
- Master 0 is the core data interface. Master 1 is a secondary requester, such as a program loader or DMA.
- Requests are granted in the same cycle. Read data returns one cycle after the grant, from the synchronous RAM.
- Fairness is round-robin or fixed-priority. Fixed-priority mode has an anti-starvation counter.

Parameters:
- FIXED_PRIO, 0: 0 = round-robin on conflict; 1 = master 0 wins conflicts.
- MAX_WAIT, 8: in fixed-priority mode, number of consecutive denied cycles for master 1 before master 1 is force-granted. Legal range 1..255.

Ports:
- clk_i  in  1  clock
- rst_n_i  in  1  asynchronous active-low reset
- m0_req_i  in  1  master 0 request
- m0_we_i  in  1  master 0 write enable
- m0_be_i  in  4  master 0 byte enables
- m0_addr_i  in  32  master 0 address
- m0_wdata_i  in  32  master 0 write data
- m0_gnt_o  out  1  master 0 granted this cycle
- m0_rvalid_o  out  1  master 0 response valid
- m0_rdata_o  out  32  master 0 read data
- m1_req_i, m1_we_i, m1_be_i, m1_addr_i, m1_wdata_i  in  1/1/4/32/32  master 1 request, same meanings as master 0
- m1_gnt_o, m1_rvalid_o, m1_rdata_o  out  1/1/32  master 1 grant and response, same meanings as master 0
- s_req_o  out  1  slave request
- s_we_o  out  1  slave write enable
- s_be_o  out  4  slave byte enables
- s_addr_o  out  32  slave address
- s_wdata_o  out  32  slave write data
- s_rdata_i  in  32  slave read data, valid one cycle after s_req_o

Behaviour:
- Clock and reset: single clock domain. Reset is asynchronous, active-low on rst_n_i.
- Reset values:
  - Registers: resp_pend=0, resp_owner=0, last_owner=1 (so master 0 wins the first conflict), wait_cnt=0.
  - Outputs: gnt_o/rvalid_o/s_req_o = 0 for both masters; all data outputs 0.
- Grant selection is combinational from the current requests and registered state:
  - Only one master requesting: that master is granted.
  - Both requesting, FIXED_PRIO=0: grant the master that is not last_owner.
  - Both requesting, FIXED_PRIO=1: grant master 0, unless wait_cnt == MAX_WAIT, in which case grant master 1.
  - Neither requesting: no grant, s_req_o=0.
- Slave mux:
  - s_req_o = OR of the grants.
  - s_we/be/addr/wdata are taken from the granted master.
  - When idle, these outputs are driven to 0 (not X).
- Grant signals: at most one gnt_o is high per cycle. gnt_o is high only while the corresponding req_i is high.
- A master holds req and payload stable until it sees gnt. A master may drop req without having been granted; nothing is issued in that case.
- Response path:
  - On each grant, the clock edge sets resp_pend=1 and resp_owner=granted index; with no grant, resp_pend=0.
  - Next cycle: rvalid_o[resp_owner] = resp_pend, for both reads and writes. rdata_o[resp_owner] = s_rdata_i; the other master's rdata_o = 0.
- Back-to-back grants are allowed every cycle (pipelined). A grant in cycle N and a response in cycle N+1 can coexist with a new grant in cycle N+1.
- last_owner is updated on every grant.
- wait_cnt (8-bit):
  - Increments when m1_req_i=1 and master 1 is not granted.
  - Clears when master 1 is granted or m1_req_i=0.
  - Saturates at MAX_WAIT.
  - In FIXED_PRIO=0 mode it is still maintained but does not affect arbitration.
- Simultaneous events: a response to one master and a grant to the other in the same cycle are independent and both occur.
- Reset mid-operation: a pending response is dropped and no rvalid is issued after reset release. A master must reissue its request.
- No address decoding: all granted accesses go to the slave. Range checking belongs to address_decoder upstream.

Test Plan:
- Single master: m0 read, addr 0x10, memory word = 0xDEADBEEF -> m0_gnt_o=1 in cycle 0; m0_rvalid_o=1 and m0_rdata_o=0xDEADBEEF in cycle 1; m1 outputs stay 0.
- Round-robin (FIXED_PRIO=0): both masters request continuously for 6 cycles from reset -> grants alternate m0,m1,m0,m1,m0,m1; each rvalid follows its grant by one cycle.
- Fixed priority with starvation (FIXED_PRIO=1, MAX_WAIT=3): both request continuously -> m0 granted cycles 0-2, m1 force-granted cycle 3, m0 granted cycles 4-6, m1 granted cycle 7.
- Write then read, pipelined: m1 writes 0xA5A5A5A5 to addr 0x20 with be=4'b0011, then reads 0x20 in the next cycle (initial word 0) -> two consecutive m1_gnt_o; m1_rvalid_o high for 2 cycles; the read returns 0x0000A5A5.
- Reset mid-operation: m0 granted a read, rst_n_i asserted asynchronously before the next edge -> m0_rvalid_o stays 0; after release, first conflict is won by m0.
- Withdrawn request: m1_req_i high for 1 cycle while m0 wins, then dropped -> m1_gnt_o and m1_rvalid_o never assert; wait_cnt returns to 0.
